// File: rtl/addsub_pipe.sv
// Two-stage add/subtract/compare unit with sign-magnitude result and valid/ready handshake.
// Optional saturation of ADD overflow and SUB underflow is enabled by defining ADDSUB_SAT_EN.
module addsub_pipe #(
  parameter int              WIDTH  = 4,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] OP_ADD = 4'b0001,
  parameter logic [OP_W-1:0] OP_SUB = 4'b0010,
  parameter logic [OP_W-1:0] OP_CMP = 4'b0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             s,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_SUB = 2'd1;
  localparam logic [1:0] CLS_CMP = 2'd2;
  localparam logic [1:0] CLS_ERR = 2'd3;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   raw_q, raw_d;
  logic [1:0]       cls_q, cls_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   out_q, out_d;
  logic             s_q, s_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             s2_load_s;
  logic             in_fire_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   neg_s;
  logic             raw_zero_s;

  assign s2_load_s  = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_load_s;
  assign in_fire_s  = in_valid && in_ready;
  assign sum_s      = {1'b0, a} + {1'b0, b};
  assign diff_s     = {1'b0, a} - {1'b0, b};
  assign neg_s      = (~raw_q) + {{WIDTH{1'b0}}, 1'b1};
  // A set borrow bit means the raw value is non-zero, so one test covers every class.
  assign raw_zero_s = (raw_q == {(WIDTH+1){1'b0}});

  // Stage 1 next state: capture a new operation, drain into stage 2, or hold.
  always_comb begin
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      case (op)
        OP_ADD:  begin cls_d = CLS_ADD; raw_d = sum_s;  end
        OP_SUB:  begin cls_d = CLS_SUB; raw_d = diff_s; end
        OP_CMP:  begin cls_d = CLS_CMP; raw_d = diff_s; end
        default: begin cls_d = CLS_ERR; raw_d = {(WIDTH+1){1'b0}}; end
      endcase
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
      cls_d      = cls_q;
      raw_d      = raw_q;
    end else begin
      s1_valid_d = s1_valid_q;
      cls_d      = cls_q;
      raw_d      = raw_q;
    end
  end

  // Stage 2 next state: turn the raw value into sign-magnitude result and flags.
  always_comb begin
    out_valid_d = s2_load_s ? s1_valid_q : out_valid_q;
    if (s2_load_s && s1_valid_q) begin
      out_d  = {(WIDTH+1){1'b0}};
      s_d    = 1'b0;
      zero_d = raw_zero_s;
      ovf_d  = 1'b0;
      err_d  = 1'b0;
      case (cls_q)
        CLS_ADD: begin
`ifdef ADDSUB_SAT_EN
          if (raw_q[WIDTH]) begin
            out_d = {1'b0, {WIDTH{1'b1}}};
            ovf_d = 1'b1;
          end else begin
            out_d = raw_q;
          end
`else
          out_d = raw_q;
`endif
        end
        CLS_SUB: begin
`ifdef ADDSUB_SAT_EN
          if (raw_q[WIDTH]) begin
            ovf_d = 1'b1;
          end else begin
            out_d = raw_q;
          end
`else
          s_d   = raw_q[WIDTH];
          out_d = raw_q[WIDTH] ? neg_s : raw_q;
`endif
        end
        CLS_CMP: begin
          s_d = raw_q[WIDTH];
        end
        default: begin
          err_d  = 1'b1;
          zero_d = 1'b0;
        end
      endcase
    end else begin
      out_d  = out_q;
      s_d    = s_q;
      zero_d = zero_q;
      ovf_d  = ovf_q;
      err_d  = err_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      raw_q       <= {(WIDTH+1){1'b0}};
      cls_q       <= CLS_ADD;
      out_valid_q <= 1'b0;
      out_q       <= {(WIDTH+1){1'b0}};
      s_q         <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      raw_q       <= raw_d;
      cls_q       <= cls_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      s_q         <= s_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign s         = s_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=4); expectations follow ADDSUB_SAT_EN when it is defined.
module tb_addsub_pipe;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] CMP = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] dout;
  logic       s;
  logic       zero;
  logic       ovf;
  logic       err;

  int total  = 0;
  int passed = 0;

  addsub_pipe #(.WIDTH(4), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .s(s), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // result packed as {out, s, zero, ovf, err}
  function automatic logic [8:0] res();
    return {dout, s, zero, ovf, err};
  endfunction

  // Issue one op with out_ready high; returns the result and the cycles until out_valid.
  task automatic run_op(input logic [3:0] op_v, input logic [3:0] a_v, input logic [3:0] b_v,
                        output logic [8:0] r, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 4'd0; b = 4'd0; op = 4'd0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    total++;
    if ({out_valid, res()} !== 10'd0) $display("FAIL reset_outputs: got %b want 0", {out_valid, res()});
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_sub();
    logic [8:0] r;
    int lat;
    run_op(SUB, 4'd3, 4'd5, r, lat);
    total++;
    if (lat !== 2) $display("FAIL sub_latency: got %0d want 2", lat);
    else passed++;
    total++;
    if (r !== (SAT ? {5'd0, 1'b0, 1'b0, 1'b1, 1'b0} : {5'd2, 1'b1, 1'b0, 1'b0, 1'b0}))
      $display("FAIL sub_3_5: got %b", r);
    else passed++;
    run_op(SUB, 4'd9, 4'd4, r, lat);
    total++;
    if (r !== {5'd5, 1'b0, 1'b0, 1'b0, 1'b0}) $display("FAIL sub_9_4: got %b want %b", r, {5'd5, 4'b0000});
    else passed++;
    run_op(SUB, 4'd7, 4'd7, r, lat);
    total++;
    if (r !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) $display("FAIL sub_7_7: got %b want %b", r, {5'd0, 4'b0100});
    else passed++;
    run_op(SUB, 4'd0, 4'd15, r, lat);
    total++;
    if (r !== (SAT ? {5'd0, 1'b0, 1'b0, 1'b1, 1'b0} : {5'd15, 1'b1, 1'b0, 1'b0, 1'b0}))
      $display("FAIL sub_0_15: got %b", r);
    else passed++;
  endtask

  task automatic test_add();
    logic [8:0] r;
    int lat;
    run_op(ADD, 4'd15, 4'd15, r, lat);
    total++;
    if (r !== (SAT ? {5'd15, 1'b0, 1'b0, 1'b1, 1'b0} : {5'd30, 1'b0, 1'b0, 1'b0, 1'b0}))
      $display("FAIL add_15_15: got %b", r);
    else passed++;
    run_op(ADD, 4'd0, 4'd0, r, lat);
    total++;
    if (r !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) $display("FAIL add_0_0: got %b want %b", r, {5'd0, 4'b0100});
    else passed++;
    run_op(ADD, 4'd6, 4'd9, r, lat);
    total++;
    if (r !== {5'd15, 1'b0, 1'b0, 1'b0, 1'b0}) $display("FAIL add_6_9: got %b want %b", r, {5'd15, 4'b0000});
    else passed++;
  endtask

  task automatic test_err_cmp();
    logic [8:0] r;
    int lat;
    run_op(4'b1111, 4'd3, 4'd1, r, lat);
    total++;
    if (r !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) $display("FAIL err_op: got %b want %b", r, {5'd0, 4'b0001});
    else passed++;
    run_op(CMP, 4'd2, 4'd8, r, lat);
    total++;
    if (r !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) $display("FAIL cmp_2_8: got %b want %b", r, {5'd0, 4'b1000});
    else passed++;
    run_op(CMP, 4'd4, 4'd4, r, lat);
    total++;
    if (r !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) $display("FAIL cmp_4_4: got %b want %b", r, {5'd0, 4'b0100});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [4];
    logic [3:0] as  [4];
    logic [3:0] bs  [4];
    logic [8:0] exp_r [4];
    int idx = 0;
    int got = 0;
    ops[0] = ADD; as[0] = 4'd1; bs[0] = 4'd2; exp_r[0] = {5'd3, 4'b0000};
    ops[1] = SUB; as[1] = 4'd8; bs[1] = 4'd3; exp_r[1] = {5'd5, 4'b0000};
    ops[2] = ADD; as[2] = 4'd4; bs[2] = 4'd6; exp_r[2] = {5'd10, 4'b0000};
    ops[3] = SUB; as[3] = 4'd2; bs[3] = 4'd9;
    exp_r[3] = SAT ? {5'd0, 1'b0, 1'b0, 1'b1, 1'b0} : {5'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 6);
      if (idx < 4) begin
        in_valid = 1'b1; op = ops[idx]; a = as[idx]; b = bs[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 5) begin
        total++;
        if ({idx[2:0], in_ready} !== {3'd2, 1'b0}) $display("FAIL b2b_stall_accept: accepted %0d in_ready %b want 2 0", idx, in_ready);
        else passed++;
        total++;
        if ({out_valid, res()} !== {1'b1, exp_r[0]}) $display("FAIL b2b_stall_hold: got %b want %b", {out_valid, res()}, {1'b1, exp_r[0]});
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (got >= 4) $display("FAIL b2b_extra_result: got %b beyond 4 results", res());
        else if (res() !== exp_r[got]) $display("FAIL b2b_result%0d: got %b want %b", got, res(), exp_r[got]);
        else passed++;
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got !== 4) $display("FAIL b2b_count: got %0d results want 4", got);
    else passed++;
  endtask

  task automatic test_reset_inflight();
    logic [8:0] r;
    int lat;
    int stale = 0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = ADD; a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    op = SUB; a = 4'd9; b = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL rst_inflight_pre: out_valid %b want 1", out_valid);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, res()} !== {1'b0, 1'b1, 9'd0}) $display("FAIL rst_inflight_clear: got %b want %b", {out_valid, in_ready, res()}, {2'b01, 9'd0});
    else passed++;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    total++;
    if (stale !== 0) $display("FAIL rst_inflight_stale: %0d stale results want 0", stale);
    else passed++;
    run_op(ADD, 4'd5, 4'd6, r, lat);
    total++;
    if ({lat[3:0], r} !== {4'd2, 5'd11, 4'b0000}) $display("FAIL rst_post_op: lat %0d res %b want 2 %b", lat, r, {5'd11, 4'b0000});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add();
    test_err_cmp();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
